// File: rtl/gem_event_pkg.sv
// Shared definitions for the GEM event collector: flavour codes and fire/halt decoding.
package gem_event_pkg;

  localparam logic [2:0] FLAV_ASSERT  = 3'd0;
  localparam logic [2:0] FLAV_ASSUME  = 3'd1;
  localparam logic [2:0] FLAV_COVER   = 3'd2;
  localparam logic [2:0] FLAV_STOP    = 3'd3;
  localparam logic [2:0] FLAV_FINISH  = 3'd4;
  localparam logic [2:0] FLAV_DISPLAY = 3'd5;

  localparam int unsigned DROP_W = 16;

  // Assert/assume fire on a failing condition, cover/stop/finish on a true one.
  function automatic logic fire_cond(input logic [2:0] flav, input logic en, input logic a);
    logic f;
    case (flav)
      FLAV_ASSERT, FLAV_ASSUME:           f = en & ~a;
      FLAV_COVER, FLAV_STOP, FLAV_FINISH: f = en & a;
      FLAV_DISPLAY:                       f = en;
      default:                            f = 1'b0;
    endcase
    return f;
  endfunction

  function automatic logic is_halt_flav(input logic [2:0] flav);
    return (flav == FLAV_STOP) || (flav == FLAV_FINISH);
  endfunction

endpackage

// File: rtl/gem_event_fifo.sv
// Generic show-ahead synchronous FIFO; pointers carry an extra wrap bit for full/empty.
module gem_event_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rn,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rn) begin
    if (!rn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/gem_event_collector.sv
// Multi-channel assertion/cover/display event collector: per-channel pending slots,
// round-robin push into a show-ahead FIFO, sticky halt and overflow tracking.
module gem_event_collector
  import gem_event_pkg::*;
#(
  parameter int unsigned       NCH     = 4,
  parameter int unsigned       DEPTH   = 8,
  parameter int unsigned       MSG_W   = 32,
  parameter int unsigned       TS_W    = 32,
  parameter logic [3*NCH-1:0]  FLAVORS = '0,
  localparam int unsigned      CW      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rn,
  input  logic [NCH-1:0]       en,
  input  logic [NCH-1:0]       a,
  input  logic [NCH*MSG_W-1:0] msg_id,
  output logic                 ev_valid,
  input  logic                 ev_ready,
  output logic [CW-1:0]        ev_chan,
  output logic [2:0]           ev_flav,
  output logic [MSG_W-1:0]     ev_msg,
  output logic [TS_W-1:0]      ev_ts,
  output logic                 ovf,
  input  logic                 clr_ovf,
  output logic [DROP_W-1:0]    drop_cnt,
  output logic                 halt
);

  typedef struct packed {
    logic [CW-1:0]    chan;
    logic [2:0]       flav;
    logic [MSG_W-1:0] msg;
    logic [TS_W-1:0]  ts;
  } event_t;

  logic [TS_W-1:0]   ts_q;
  logic [NCH-1:0]    pend_vld_q, pend_vld_d;
  logic [MSG_W-1:0]  pend_msg_q [NCH];
  logic [MSG_W-1:0]  pend_msg_d [NCH];
  logic [TS_W-1:0]   pend_ts_q [NCH];
  logic [TS_W-1:0]   pend_ts_d [NCH];
  logic [CW-1:0]     rr_ptr_q, rr_ptr_d;
  logic              ovf_q, ovf_d, halt_q, halt_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [DROP_W:0]   drop_sum;
  logic              any_drop;

  logic [2:0]        flav [NCH];
  logic [NCH-1:0]    fire;
  logic              gnt_vld, push, pop, fifo_full, fifo_empty;
  logic [CW-1:0]     gnt_idx, cand;
  event_t            push_ev, head_ev, out_ev;

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      flav[i] = FLAVORS[3*i +: 3];
      fire[i] = fire_cond(flav[i], en[i], a[i]);
    end
  end

  assign pop = ~fifo_empty & ev_ready;

  // Round-robin search starting at the pointer; grant only when the FIFO can take it.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      cand = CW'((32'(rr_ptr_q) + k) % NCH);
      if (!gnt_vld && pend_vld_q[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign push = gnt_vld & (~fifo_full | pop);

  always_comb begin
    push_ev.chan = gnt_idx;
    push_ev.flav = flav[gnt_idx];
    push_ev.msg  = pend_msg_q[gnt_idx];
    push_ev.ts   = pend_ts_q[gnt_idx];
  end

  always_comb begin
    pend_vld_d = pend_vld_q;
    pend_msg_d = pend_msg_q;
    pend_ts_d  = pend_ts_q;
    halt_d     = halt_q;
    drop_sum   = {1'b0, drop_cnt_q};
    any_drop   = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      // A slot drained this cycle is free to accept a new fire without dropping.
      if (push && (gnt_idx == CW'(i))) pend_vld_d[i] = 1'b0;
      if (fire[i]) begin
        if (is_halt_flav(flav[i])) halt_d = 1'b1;
        if (pend_vld_d[i]) begin
          any_drop = 1'b1;
          drop_sum = drop_sum + 17'd1;
        end else begin
          pend_vld_d[i] = 1'b1;
          pend_msg_d[i] = msg_id[MSG_W*i +: MSG_W];
          pend_ts_d[i]  = ts_q;
        end
      end
    end
    drop_cnt_d = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
    ovf_d      = any_drop ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);
    if (push) rr_ptr_d = (gnt_idx == CW'(NCH - 1)) ? '0 : gnt_idx + 1'b1;
    else      rr_ptr_d = rr_ptr_q;
  end

  always_ff @(posedge clk or negedge rn) begin
    if (!rn) begin
      ts_q       <= '0;
      pend_vld_q <= '0;
      rr_ptr_q   <= '0;
      ovf_q      <= 1'b0;
      halt_q     <= 1'b0;
      drop_cnt_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        pend_msg_q[i] <= '0;
        pend_ts_q[i]  <= '0;
      end
    end else begin
      ts_q       <= ts_q + 1'b1;
      pend_vld_q <= pend_vld_d;
      pend_msg_q <= pend_msg_d;
      pend_ts_q  <= pend_ts_d;
      rr_ptr_q   <= rr_ptr_d;
      ovf_q      <= ovf_d;
      halt_q     <= halt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  gem_event_fifo #(
    .WIDTH ($bits(event_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rn    (rn),
    .push  (push),
    .wdata (push_ev),
    .pop   (pop),
    .rdata (head_ev),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Head data is forced to zero whenever nothing is queued, including during reset.
  assign out_ev   = fifo_empty ? '0 : head_ev;
  assign ev_valid = ~fifo_empty;
  assign ev_chan  = out_ev.chan;
  assign ev_flav  = out_ev.flav;
  assign ev_msg   = out_ev.msg;
  assign ev_ts    = out_ev.ts;
  assign ovf      = ovf_q;
  assign halt     = halt_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_gem_event_collector.sv
// Randomised and directed bench for gem_event_collector against a queue-based reference model.
module tb_gem_event_collector;

  localparam int NCH   = 4;
  localparam int DEPTH = 8;
  // ch0 cover, ch1 assert, ch2 finish, ch3 display
  localparam logic [11:0] FLAVS = {3'd5, 3'd4, 3'd0, 3'd2};

  logic         clk      = 1'b0;
  logic         rn       = 1'b0;
  logic [3:0]   en       = '0;
  logic [3:0]   a        = '0;
  logic [127:0] msg_id   = '0;
  logic         ev_ready = 1'b0;
  logic         clr_ovf  = 1'b0;
  logic         ev_valid;
  logic [1:0]   ev_chan;
  logic [2:0]   ev_flav;
  logic [31:0]  ev_msg;
  logic [31:0]  ev_ts;
  logic         ovf;
  logic [15:0]  drop_cnt;
  logic         halt;

  always #5 clk = ~clk;

  gem_event_collector #(
    .NCH     (NCH),
    .DEPTH   (DEPTH),
    .MSG_W   (32),
    .TS_W    (32),
    .FLAVORS (FLAVS)
  ) dut (
    .clk      (clk),
    .rn       (rn),
    .en       (en),
    .a        (a),
    .msg_id   (msg_id),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .ev_chan  (ev_chan),
    .ev_flav  (ev_flav),
    .ev_msg   (ev_msg),
    .ev_ts    (ev_ts),
    .ovf      (ovf),
    .clr_ovf  (clr_ovf),
    .drop_cnt (drop_cnt),
    .halt     (halt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending slots, an event queue and counters, stepped once per clock.
  typedef struct {
    int          chan;
    int          flav;
    logic [31:0] msg;
    logic [31:0] ts;
  } ev_t;

  ev_t         exp_q[$];
  int          ch_flav[NCH] = '{2, 0, 4, 5};
  bit          m_pv[NCH];
  logic [31:0] m_msg[NCH];
  logic [31:0] m_pts[NCH];
  int          m_rr = 0;
  logic [31:0] m_ts = '0;
  bit          m_ovf = 0;
  bit          m_halt = 0;
  int          m_drop = 0;
  bit          m_pop;
  int          m_g;
  int          m_nd;

  function automatic bit fires(input int f, input logic e, input logic x);
    if (f == 0 || f == 1) return e && !x;
    if (f >= 2 && f <= 4) return e && x;
    if (f == 5) return e;
    return 0;
  endfunction

  initial forever begin
    @(posedge clk or negedge rn);
    if (!rn) begin
      exp_q.delete();
      for (int i = 0; i < NCH; i++) m_pv[i] = 0;
      m_rr = 0; m_ts = '0; m_ovf = 0; m_halt = 0; m_drop = 0;
    end else begin
      m_pop = (exp_q.size() > 0) && ev_ready;
      m_g   = -1;
      if (exp_q.size() < DEPTH || m_pop)
        for (int k = 0; k < NCH; k++)
          if (m_g < 0 && m_pv[(m_rr + k) % NCH]) m_g = (m_rr + k) % NCH;
      if (m_pop) exp_q.delete(0);
      if (m_g >= 0) begin
        exp_q.push_back('{m_g, ch_flav[m_g], m_msg[m_g], m_pts[m_g]});
        m_pv[m_g] = 0;
        m_rr = (m_g + 1) % NCH;
      end
      m_nd = 0;
      for (int i = 0; i < NCH; i++) begin
        if (fires(ch_flav[i], en[i], a[i])) begin
          if (ch_flav[i] == 3 || ch_flav[i] == 4) m_halt = 1;
          if (m_pv[i]) m_nd++;
          else begin
            m_pv[i] = 1;
            m_msg[i] = msg_id[32*i +: 32];
            m_pts[i] = m_ts;
          end
        end
      end
      if (m_nd > 0) m_ovf = 1;
      else if (clr_ovf) m_ovf = 0;
      m_drop = (m_drop + m_nd > 65535) ? 65535 : m_drop + m_nd;
      m_ts = m_ts + 1;
    end
  end

  // Every-cycle comparison against the model, sampled mid-period.
  initial forever begin
    @(negedge clk);
    if (!rn) begin
      check("rst_valid", ev_valid, 0);
      check("rst_ts", ev_ts, 0);
      check("rst_halt", halt, 0);
      check("rst_drop", drop_cnt, 0);
    end else begin
      check("valid", ev_valid, exp_q.size() > 0);
      if (exp_q.size() > 0) begin
        check("chan", ev_chan, exp_q[0].chan);
        check("flav", ev_flav, exp_q[0].flav);
        check("msg", ev_msg, exp_q[0].msg);
        check("ts", ev_ts, exp_q[0].ts);
      end
      check("ovf", ovf, m_ovf);
      check("drop_cnt", drop_cnt, m_drop);
      check("halt", halt, m_halt);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int          n_ev;
  logic [31:0] last_ts;
  logic [31:0] last_msg;

  initial begin
    // T1 reset defaults
    repeat (3) @(negedge clk);
    rn = 1'b1;
    repeat (3) @(negedge clk);
    check("t1_valid", ev_valid, 0);
    check("t1_ovf", ovf, 0);
    check("t1_drop", drop_cnt, 0);
    check("t1_halt", halt, 0);

    // T2 single assert on ch1, latency 2
    en = 4'b0010; a = 4'b0000; msg_id[63:32] = 32'hCAFE;
    @(negedge clk); en = '0;
    check("t2_lat1_valid", ev_valid, 0);
    @(negedge clk);
    check("t2_valid", ev_valid, 1);
    check("t2_chan", ev_chan, 1);
    check("t2_flav", ev_flav, 0);
    check("t2_msg", ev_msg, 32'hCAFE);
    check("t1_first_ts", ev_ts, 3);
    ev_ready = 1'b1;
    @(negedge clk);
    check("t2_popped", ev_valid, 0);
    en = 4'b0010; a = 4'b0010;
    @(negedge clk); en = '0; a = '0;
    repeat (3) begin
      @(negedge clk);
      check("t2_no_fire", ev_valid, 0);
    end

    // T4 full FIFO with backpressure on ch0
    ev_ready = 1'b0; en = 4'b0001; a = 4'b0001;
    for (int c = 0; c < 12; c++) begin
      msg_id[31:0] = 32'h100 + c;
      @(negedge clk);
    end
    en = '0; a = '0;
    check("t4_drop_cnt", drop_cnt, 3);
    check("t4_ovf", ovf, 1);
    check("t4_valid", ev_valid, 1);
    ev_ready = 1'b1; n_ev = 0; last_ts = '0; last_msg = '0;
    for (int c = 0; c < 14; c++) begin
      if (ev_valid) begin
        if (n_ev > 0) check("t4_ts_incr", ev_ts > last_ts, 1);
        last_ts = ev_ts; last_msg = ev_msg; n_ev++;
      end
      @(negedge clk);
    end
    check("t4_events", n_ev, 9);
    check("t4_last_msg", last_msg, 32'h108);
    clr_ovf = 1'b1;
    @(negedge clk); clr_ovf = 1'b0;
    check("t4_ovf_clr", ovf, 0);
    check("t4_drop_kept", drop_cnt, 3);

    // T5 halt on finish, display keeps flowing
    check("t5_halt_pre", halt, 0);
    en = 4'b0100; a = 4'b0100;
    @(negedge clk); en = '0; a = '0;
    check("t5_halt", halt, 1);
    n_ev = 0; en = 4'b1000;
    for (int c = 0; c < 12; c++) begin
      if (c == 3) en = '0;
      if (ev_valid && ev_chan == 2'd3) n_ev++;
      @(negedge clk);
    end
    check("t5_display_events", n_ev, 3);
    check("t5_halt_sticky", halt, 1);

    // T3 simultaneous fires, two bursts
    for (int b = 0; b < 2; b++) begin
      en = 4'b1111; a = 4'b0101;
      msg_id = {32'h33, 32'h22, 32'h11, 32'h00};
      @(negedge clk); en = '0; a = '0;
      check("t3_gap", ev_valid, 0);
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        check("t3_valid", ev_valid, 1);
        check("t3_order", ev_chan, k);
      end
      @(negedge clk);
      check("t3_empty", ev_valid, 0);
    end

    // Random traffic, alternating light and heavy backpressure
    for (int c = 0; c < 400; c++) begin
      en = 4'($urandom); a = 4'($urandom);
      msg_id = {$urandom, $urandom, $urandom, $urandom};
      ev_ready = ((c / 50) % 2 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      clr_ovf = ($urandom_range(0, 15) == 0);
      @(negedge clk);
    end
    en = '0; a = '0; clr_ovf = 1'b0;

    // T6 asynchronous reset with events queued
    ev_ready = 1'b1;
    repeat (12) @(negedge clk);
    ev_ready = 1'b0; en = 4'b1000;
    repeat (5) @(negedge clk);
    en = '0;
    repeat (2) @(negedge clk);
    check("t6_queued", ev_valid, 1);
    #2 rn = 1'b0;
    #1;
    check("t6_async_valid", ev_valid, 0);
    check("t6_async_halt", halt, 0);
    check("t6_async_ovf", ovf, 0);
    check("t6_async_drop", drop_cnt, 0);
    check("t6_async_ts", ev_ts, 0);
    @(negedge clk); rn = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("t6_empty", ev_valid, 0);
    end
    en = 4'b0010; a = 4'b0000; msg_id[63:32] = 32'h5A5A;
    @(negedge clk); en = '0;
    @(negedge clk);
    check("t6_valid", ev_valid, 1);
    check("t6_chan", ev_chan, 1);
    check("t6_msg", ev_msg, 32'h5A5A);
    check("t6_ts_restart", ev_ts, 3);
    ev_ready = 1'b1;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
